// File: rtl/gpio_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_input_conditioner_pkg
//  Purpose  : Shared defaults and sizing helper for the GPIO input
//             conditioner and its per-bit debounce slice.
//  Contents : DEFAULT_PRESCALE, DEFAULT_STABLE_TICKS, cnt_width()
//  Revision : 1.0 - initial release
// ============================================================================
package gpio_input_conditioner_pkg;

    localparam int DEFAULT_PRESCALE     = 1000;
    localparam int DEFAULT_STABLE_TICKS = 4;

    // Bits needed to hold values 0..max_val. The result is never below 1, so
    // degenerate configurations (PRESCALE=1, STABLE_TICKS=1) still produce
    // legal vector widths.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : gpio_input_conditioner_pkg
`default_nettype wire

// File: rtl/gpio_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_debounce_bit
//  Purpose  : One conditioned GPIO input: two-flop synchronizer, saturating
//             stability counter and accepted-edge pulse generation.
//  Ports    : clk    - system clock
//             resetn - asynchronous active-low reset
//             pin    - raw asynchronous pad input
//             tick   - shared prescaler sample strobe (one cycle)
//             level  - registered debounced level
//             rise   - one-cycle pulse on an accepted 0->1 change
//             fall   - one-cycle pulse on an accepted 1->0 change
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_debounce_bit
    import gpio_input_conditioner_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    input  logic tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              C_CW   = cnt_width(STABLE_TICKS);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(STABLE_TICKS - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;
    logic [C_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= pin;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                // Any cycle agreeing with the accepted level restarts the
                // stability count, even between sample ticks.
                r_cnt <= '0;
            end else if (tick) begin
                if (r_cnt == C_LAST) begin
                    // This tick is the STABLE_TICKS-th differing sample.
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_rise  <= r_sync2;
                    r_fall  <= ~r_sync2;
                end else begin
                    // Counter never exceeds C_LAST, so it saturates there.
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule : gpio_debounce_bit
`default_nettype wire

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_input_conditioner
//  Purpose  : Synchronizes and debounces WIDTH raw pad inputs, producing
//             stable levels plus per-bit rise/fall pulses. One shared
//             prescaler sets the debounce sample rate.
//  Ports    : clk         - system clock
//             resetn      - asynchronous active-low reset
//             gpio_pins_i - raw asynchronous pad inputs [WIDTH]
//             gpio_o      - registered debounced levels [WIDTH]
//             rise_o      - accepted 0->1 pulses [WIDTH]
//             fall_o      - accepted 1->0 pulses [WIDTH]
//             tick_o      - registered sample-tick pulse
//  Revision : 1.0 - initial release
// ============================================================================
module gpio_input_conditioner
    import gpio_input_conditioner_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int PRESCALE     = DEFAULT_PRESCALE,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] gpio_pins_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             tick_o
);

    localparam int              C_PW        = cnt_width(PRESCALE - 1);
    localparam logic [C_PW-1:0] C_PRES_LAST = C_PW'(PRESCALE - 1);

    logic [C_PW-1:0] r_presc;
    logic            r_tick;
    logic            w_tick;

    // With PRESCALE=1 the counter is pinned at 0 and w_tick is always high.
    assign w_tick = (r_presc == C_PRES_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= w_tick;
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    assign tick_o = r_tick;

    // The unregistered tick feeds the slices so the sample decision and the
    // prescaler wrap happen on the same edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_bit (
            .clk    (clk),
            .resetn (resetn),
            .pin    (gpio_pins_i[i]),
            .tick   (w_tick),
            .level  (gpio_o[i]),
            .rise   (rise_o[i]),
            .fall   (fall_o[i])
        );
    end

endmodule : gpio_input_conditioner
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_input_conditioner
//  Purpose  : Self-checking bench for gpio_input_conditioner with
//             PRESCALE=4, STABLE_TICKS=3, WIDTH=32.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_input_conditioner;

    localparam int W  = 32;
    localparam int P  = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] gpio_pins_i = '0;
    logic [W-1:0] gpio_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic         tick_o;

    int checks = 0;
    int errors = 0;

    gpio_input_conditioner #(
        .WIDTH        (W),
        .PRESCALE     (P),
        .STABLE_TICKS (ST)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .gpio_pins_i (gpio_pins_i),
        .gpio_o      (gpio_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .tick_o      (tick_o)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. n counts rising edges since reset release; the
    // interval after edge n samples at a tick when n mod P == P-1.
    // Each bit remembers the last interval in which its synchronized pin
    // matched the accepted level; a new level is accepted on a tick when
    // exactly ST ticks have elapsed since then.
    // ------------------------------------------------------------------
    int           n;
    logic [W-1:0] m_gpio, m_rise, m_fall, m_s1, m_s2;
    logic         m_tick;
    int           last_eq [W];

    function automatic int ticks_upto(input int x);
        return (x + 1) / P;
    endfunction

    function automatic void model_reset();
        n      = 0;
        m_gpio = '0; m_rise = '0; m_fall = '0; m_s1 = '0; m_s2 = '0;
        m_tick = 1'b0;
        for (int b = 0; b < W; b++) last_eq[b] = -1;
    endfunction

    // Drive pins for the next edge, advance one clock, update the model.
    task automatic step(input logic [W-1:0] pins);
        logic         tk;
        logic [W-1:0] ng, nr, nf;
        gpio_pins_i = pins;
        tk = ((n % P) == P - 1);
        ng = m_gpio; nr = '0; nf = '0;
        for (int b = 0; b < W; b++) begin
            if (m_s2[b] == m_gpio[b]) begin
                last_eq[b] = n;
            end else if (tk && (ticks_upto(n) - ticks_upto(last_eq[b]) == ST)) begin
                ng[b] = m_s2[b];
                nr[b] = m_s2[b];
                nf[b] = ~m_s2[b];
                last_eq[b] = n;
            end
        end
        @(posedge clk); #1;
        m_gpio = ng; m_rise = nr; m_fall = nf; m_tick = tk;
        m_s2 = m_s1; m_s1 = pins;
        n++;
    endtask

    // Hold reset across a few edges with the given pins, then release.
    task automatic hold_reset(input logic [W-1:0] pins, input int cyc);
        gpio_pins_i = pins;
        resetn = 1'b0;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        resetn = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int all_rise = 0;
        hold_reset('1, 3);
        checks++; if (gpio_o !== '0) begin errors++; $display("FAIL reset_gpio got=%h want=%h", gpio_o, 32'h0); end
        checks++; if (rise_o !== '0) begin errors++; $display("FAIL reset_rise got=%h want=%h", rise_o, 32'h0); end
        checks++; if (fall_o !== '0) begin errors++; $display("FAIL reset_fall got=%h want=%h", fall_o, 32'h0); end
        checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", tick_o); end
        release_reset();
        for (int c = 0; c < 30; c++) begin
            step('1);
            checks++;
            if (gpio_o !== m_gpio || rise_o !== m_rise || fall_o !== m_fall || tick_o !== m_tick) begin
                errors++;
                $display("FAIL reset_release n=%0d got g=%h r=%h f=%h t=%b want g=%h r=%h f=%h t=%b",
                         n, gpio_o, rise_o, fall_o, tick_o, m_gpio, m_rise, m_fall, m_tick);
            end
            if (rise_o === '1) all_rise++;
        end
        checks++; if (all_rise != 1) begin errors++; $display("FAIL reset_all_rise_count got=%0d want=1", all_rise); end
        checks++; if (gpio_o !== '1) begin errors++; $display("FAIL reset_final_gpio got=%h want=%h", gpio_o, 32'hFFFF_FFFF); end
    endtask

    task automatic test_rise_bit5();
        int rises = 0;
        int first_n = -1;
        hold_reset('0, 2);
        release_reset();
        repeat (5) step('0);
        // Pin sampled at edge 6, sync2 valid from n=7; ticks at n=7,11,15,
        // so gpio_o[5] rises after edge 16.
        for (int c = 0; c < 20; c++) begin
            step(32'h20);
            checks++;
            if (gpio_o !== m_gpio || rise_o !== m_rise || fall_o !== m_fall || tick_o !== m_tick) begin
                errors++;
                $display("FAIL bit5_rise n=%0d got g=%h r=%h f=%h t=%b want g=%h r=%h f=%h t=%b",
                         n, gpio_o, rise_o, fall_o, tick_o, m_gpio, m_rise, m_fall, m_tick);
            end
            if (rise_o[5]) rises++;
            if (gpio_o[5] && first_n < 0) first_n = n;
        end
        checks++; if (rises != 1) begin errors++; $display("FAIL bit5_pulse_count got=%0d want=1", rises); end
        checks++; if (first_n != 16) begin errors++; $display("FAIL bit5_latency got=%0d want=16", first_n); end
    endtask

    task automatic test_glitch();
        int rises = 0;
        for (int c = 0; c < 26; c++) begin
            step((c < 6) ? 32'h21 : 32'h20);
            checks++;
            if (gpio_o !== m_gpio || rise_o !== m_rise || fall_o !== m_fall || tick_o !== m_tick) begin
                errors++;
                $display("FAIL glitch n=%0d got g=%h r=%h f=%h t=%b want g=%h r=%h f=%h t=%b",
                         n, gpio_o, rise_o, fall_o, tick_o, m_gpio, m_rise, m_fall, m_tick);
            end
            if (rise_o[0]) rises++;
        end
        checks++; if (rises != 0) begin errors++; $display("FAIL glitch_rise0 got=%0d want=0", rises); end
        checks++; if (gpio_o[0] !== 1'b0) begin errors++; $display("FAIL glitch_gpio0 got=%b want=0", gpio_o[0]); end
    endtask

    task automatic test_fall_pair();
        int pair = 0;
        repeat (20) step(32'hA8);
        checks++; if (gpio_o !== 32'hA8) begin errors++; $display("FAIL fall_setup got=%h want=%h", gpio_o, 32'hA8); end
        for (int c = 0; c < 20; c++) begin
            step(32'h20);
            checks++;
            if (gpio_o !== m_gpio || rise_o !== m_rise || fall_o !== m_fall || tick_o !== m_tick) begin
                errors++;
                $display("FAIL fall_pair n=%0d got g=%h r=%h f=%h t=%b want g=%h r=%h f=%h t=%b",
                         n, gpio_o, rise_o, fall_o, tick_o, m_gpio, m_rise, m_fall, m_tick);
            end
            if (fall_o === 32'h88 && rise_o === '0) pair++;
        end
        checks++; if (pair != 1) begin errors++; $display("FAIL fall_pair_count got=%0d want=1", pair); end
        checks++; if (gpio_o !== 32'h20) begin errors++; $display("FAIL fall_final got=%h want=%h", gpio_o, 32'h20); end
    endtask

    task automatic test_reset_mid();
        hold_reset('0, 2);
        release_reset();
        // sync2 high from n=2, ticks at n=3 and n=7 counted by n=9.
        repeat (9) step(32'h2);
        resetn = 1'b0;
        #1;
        checks++; if (gpio_o !== '0 || rise_o !== '0 || fall_o !== '0 || tick_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got g=%h r=%h f=%h t=%b want all zero", gpio_o, rise_o, fall_o, tick_o);
        end
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        for (int c = 0; c < 16; c++) begin
            step(32'h2);
            checks++;
            if (gpio_o !== m_gpio || rise_o !== m_rise || fall_o !== m_fall || tick_o !== m_tick) begin
                errors++;
                $display("FAIL midreset_run n=%0d got g=%h r=%h f=%h t=%b want g=%h r=%h f=%h t=%b",
                         n, gpio_o, rise_o, fall_o, tick_o, m_gpio, m_rise, m_fall, m_tick);
            end
            // Full three ticks (n=3,7,11) required again: accept after edge 12.
            if (n == 11) begin
                checks++; if (gpio_o[1] !== 1'b0) begin errors++; $display("FAIL midreset_early got=%b want=0", gpio_o[1]); end
            end
            if (n == 12) begin
                checks++; if (gpio_o[1] !== 1'b1 || rise_o[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_accept got g=%b r=%b want g=1 r=1", gpio_o[1], rise_o[1]);
                end
            end
        end
    endtask

    task automatic test_tick();
        int ticks = 0;
        for (int c = 0; c < 40; c++) begin
            step(32'h2);
            checks++;
            if (tick_o !== ((n % P) == 0)) begin
                errors++;
                $display("FAIL tick_phase n=%0d got=%b want=%b", n, tick_o, ((n % P) == 0));
            end
            if (tick_o) ticks++;
        end
        checks++; if (ticks != 10) begin errors++; $display("FAIL tick_count got=%0d want=10", ticks); end
    endtask

    task automatic test_random();
        logic [W-1:0] pins;
        int           hold;
        pins = 32'h2;
        for (int c = 0; c < 600; c++) begin
            if (hold <= 0) begin
                pins = pins ^ ($urandom & $urandom);
                hold = $urandom_range(1, 14);
            end
            hold--;
            step(pins);
            checks++;
            if (gpio_o !== m_gpio || rise_o !== m_rise || fall_o !== m_fall || tick_o !== m_tick) begin
                errors++;
                $display("FAIL random n=%0d got g=%h r=%h f=%h t=%b want g=%h r=%h f=%h t=%b",
                         n, gpio_o, rise_o, fall_o, tick_o, m_gpio, m_rise, m_fall, m_tick);
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_rise_bit5();
        test_glitch();
        test_fall_pair();
        test_reset_mid();
        test_tick();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gpio_input_conditioner
`default_nettype wire
